// File: rtl/vegetable_eater.sv
// -----------------------------------------------------------------------------
// vegetable_eater
//
// Consumer end of the vegetable position interface. Each clock the pig
// bounding box is compared against the current vegetable box; an overlap
// that persists for HIT_CYCLES consecutive samples is a bite. A bite issues
// a one-cycle new_round pulse (the locator respawns the vegetable on it),
// grows the pig and bumps the score, then the block sits in a cooldown so
// the comparators see the relocated vegetable before re-arming.
//
// Ports
//   clk        in   1   system clock
//   rst        in   1   synchronous active-high reset
//   start      in   1   leaves IDLE, clears score and growth (ignored elsewhere)
//   pigX/pigY  in  11   pig top-left corner
//   posX/posY  in  11   vegetable top-left corner
//   posX_end   in  11   vegetable right edge
//   posY_end   in  11   vegetable bottom edge
//   new_round  out  1   registered one-cycle respawn pulse
//   pig_growth out 11   registered pig growth (saturates at MAX_GROWTH)
//   score      out  8   registered bites eaten (saturates at 255)
//   armed      out  1   registered, high while waiting for a bite
// -----------------------------------------------------------------------------
module vegetable_eater #(
  parameter int PIG_SIZE        = 40,
  parameter int GROWTH_STEP     = 4,
  parameter int MAX_GROWTH      = 40,
  parameter int HIT_CYCLES      = 2,
  parameter int COOLDOWN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] pigX,
  input  logic [10:0] pigY,
  input  logic [10:0] posX,
  input  logic [10:0] posY,
  input  logic [10:0] posX_end,
  input  logic [10:0] posY_end,
  output logic        new_round,
  output logic [10:0] pig_growth,
  output logic [7:0]  score,
  output logic        armed
);

  localparam logic [11:0] SIZE_12  = 12'(PIG_SIZE);
  localparam logic [11:0] STEP_12  = 12'(GROWTH_STEP);
  localparam logic [11:0] MAX_12   = 12'(MAX_GROWTH);
  localparam logic [7:0]  HIT_LAST = 8'(HIT_CYCLES - 1);
  localparam logic [7:0]  CD_LAST  = 8'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_EAT      = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  hit_q, hit_d;
  logic [7:0]  cd_q, cd_d;
  logic [10:0] growth_q, growth_d;
  logic [7:0]  score_q, score_d;
  logic        new_round_q, new_round_d;
  logic        armed_q, armed_d;

  logic [11:0] left_s, right_s, top_s, bottom_s;
  logic        overlap_s;
  logic        bite_s;
  logic [11:0] growth_sum_s;

  // Lower box edge: corner minus growth, clamped at zero instead of wrapping.
  function automatic logic [11:0] low_edge(input logic [10:0] corner,
                                           input logic [10:0] growth);
    logic [11:0] edge_v;
    if (growth > corner) begin
      edge_v = 12'd0;
    end else begin
      edge_v = {1'b0, corner} - {1'b0, growth};
    end
    return edge_v;
  endfunction

  // Upper box edge: 11-bit corner plus pig size always fits in 12 bits.
  function automatic logic [11:0] high_edge(input logic [10:0] corner);
    return {1'b0, corner} + SIZE_12;
  endfunction

  // Pig box and inclusive overlap test against the vegetable box.
  always_comb begin
    left_s    = low_edge(pigX, growth_q);
    right_s   = high_edge(pigX);
    top_s     = low_edge(pigY, growth_q);
    bottom_s  = high_edge(pigY);
    overlap_s = ({1'b0, posX_end} >= left_s)  && ({1'b0, posX} <= right_s) &&
                ({1'b0, posY_end} >= top_s)   && ({1'b0, posY} <= bottom_s);
  end

  // A bite is the armed overlap sample that completes the debounce count.
  always_comb begin
    if (state_q == ST_ARMED) begin
      bite_s = overlap_s && (hit_q == HIT_LAST);
    end else begin
      bite_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (bite_s) begin
          state_d = ST_EAT;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_EAT: begin
        state_d = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (cd_q == CD_LAST) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_COOLDOWN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Counters, growth/score updates and registered outputs. Growth and score
  // are updated on the same edge that raises new_round (the ARMED->EAT edge).
  always_comb begin
    hit_d        = hit_q;
    cd_d         = cd_q;
    growth_d     = growth_q;
    score_d      = score_q;
    new_round_d  = 1'b0;
    armed_d      = (state_d == ST_ARMED);
    growth_sum_s = {1'b0, growth_q} + STEP_12;
    case (state_q)
      ST_IDLE: begin
        cd_d = 8'd0;
        if (start) begin
          score_d  = 8'd0;
          growth_d = 11'd0;
          hit_d    = 8'd0;
        end else begin
          hit_d = hit_q;
        end
      end
      ST_ARMED: begin
        if (bite_s) begin
          hit_d       = 8'd0;
          new_round_d = 1'b1;
          if (growth_sum_s > MAX_12) begin
            growth_d = MAX_12[10:0];
          end else begin
            growth_d = growth_sum_s[10:0];
          end
          if (score_q == 8'd255) begin
            score_d = 8'd255;
          end else begin
            score_d = score_q + 8'd1;
          end
        end else if (overlap_s) begin
          hit_d = hit_q + 8'd1;
        end else begin
          // Any gap in the overlap restarts the debounce.
          hit_d = 8'd0;
        end
      end
      ST_EAT: begin
        cd_d = 8'd0;
      end
      ST_COOLDOWN: begin
        if (cd_q == CD_LAST) begin
          cd_d  = 8'd0;
          hit_d = 8'd0;
        end else begin
          cd_d = cd_q + 8'd1;
        end
      end
      default: begin
        hit_d = 8'd0;
        cd_d  = 8'd0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q       <= 8'd0;
      cd_q        <= 8'd0;
      growth_q    <= 11'd0;
      score_q     <= 8'd0;
      new_round_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      hit_q       <= hit_d;
      cd_q        <= cd_d;
      growth_q    <= growth_d;
      score_q     <= score_d;
      new_round_q <= new_round_d;
      armed_q     <= armed_d;
    end
  end

  assign new_round  = new_round_q;
  assign pig_growth = growth_q;
  assign score      = score_q;
  assign armed      = armed_q;

endmodule

// File: tb/tb_vegetable_eater.sv
// -----------------------------------------------------------------------------
// tb_vegetable_eater
//
// Directed scenarios plus randomized traffic. A timeline reference model
// (edge numbers, overlap streak, earliest edge at which the eater is ready
// again) predicts new_round, armed, score and pig_growth after every edge.
// -----------------------------------------------------------------------------
module tb_vegetable_eater;

  localparam int P_SIZE   = 40;
  localparam int P_STEP   = 4;
  localparam int P_MAX    = 40;
  localparam int P_HIT    = 2;
  localparam int P_COOL   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] pig_x, pig_y, pos_x, pos_y, pos_x_end, pos_y_end;
  logic        new_round;
  logic [10:0] pig_growth;
  logic [7:0]  score;
  logic        armed;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int edge_no   = 0;
  int m_started = 0;
  int m_ready   = 0;   // edge at which the eater (re)entered waiting
  int m_streak  = 0;
  int m_growth  = 0;
  int m_score   = 0;
  int m_pulse   = 0;

  always #5 clk = ~clk;

  vegetable_eater #(
    .PIG_SIZE(P_SIZE), .GROWTH_STEP(P_STEP), .MAX_GROWTH(P_MAX),
    .HIT_CYCLES(P_HIT), .COOLDOWN_CYCLES(P_COOL)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .pigX(pig_x), .pigY(pig_y),
    .posX(pos_x), .posY(pos_y), .posX_end(pos_x_end), .posY_end(pos_y_end),
    .new_round(new_round), .pig_growth(pig_growth), .score(score), .armed(armed)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  function automatic bit ref_overlap(int px, int py, int g, int vx, int vy, int vxe, int vye);
    int l, r, t, b;
    l = px - g; if (l < 0) l = 0;
    t = py - g; if (t < 0) t = 0;
    r = px + P_SIZE;
    b = py + P_SIZE;
    return (vxe >= l) && (vx <= r) && (vye >= t) && (vy <= b);
  endfunction

  // Apply one clock edge to the model using the inputs the DUT just sampled.
  task automatic model_edge();
    edge_no++;
    m_pulse = 0;
    if (rst) begin
      m_started = 0; m_score = 0; m_growth = 0; m_streak = 0;
    end else if (m_started == 0) begin
      if (start) begin
        m_started = 1; m_score = 0; m_growth = 0; m_streak = 0; m_ready = edge_no;
      end
    end else if (edge_no > m_ready) begin
      if (ref_overlap(pig_x, pig_y, m_growth, pos_x, pos_y, pos_x_end, pos_y_end))
        m_streak++;
      else
        m_streak = 0;
      if (m_streak == P_HIT) begin
        m_pulse  = 1;
        m_growth = (m_growth + P_STEP > P_MAX) ? P_MAX : m_growth + P_STEP;
        m_score  = (m_score == 255) ? 255 : m_score + 1;
        m_streak = 0;
        m_ready  = edge_no + 1 + P_COOL;  // one EAT cycle, then cooldown
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_val("new_round", 32'(new_round), 32'(m_pulse));
    check_val("armed", 32'(armed), 32'((m_started != 0) && (edge_no >= m_ready)));
    check_val("score", 32'(score), 32'(m_score));
    check_val("pig_growth", 32'(pig_growth), 32'(m_growth));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_pig(input int x, input int y);
    pig_x = 11'(x); pig_y = 11'(y);
  endtask

  task automatic set_veg(input int x, input int y, input int w);
    pos_x = 11'(x); pos_y = 11'(y);
    pos_x_end = 11'(x + w); pos_y_end = 11'(y + w);
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  int vx, vy;

  initial begin
    rst = 1'b1; start = 1'b0;
    set_pig(100, 100);
    set_veg(300, 300, 20);
    steps(2);
    rst = 1'b0;
    steps(2);
    pulse_start();                 // armed one cycle later, score/growth 0

    // Basic bite: 2 cycles of overlap, then vegetable moved away
    set_veg(130, 130, 20); steps(2);
    set_veg(300, 300, 20); steps(8);

    // Debounce: single overlap sample must not bite
    set_veg(130, 130, 20); steps(1);
    set_veg(300, 300, 20); steps(4);
    set_veg(130, 130, 20); steps(1);
    set_veg(300, 300, 20); steps(1);
    set_veg(130, 130, 20); steps(1);
    set_veg(300, 300, 20); steps(3);

    // Reset during cooldown
    set_veg(130, 130, 20); steps(4);
    rst = 1'b1; steps(1); rst = 1'b0;
    set_veg(300, 300, 20); steps(2);
    pulse_start();

    // Edge/growth boundary: (60..80) misses at growth 0, touches at growth 20
    set_veg(60, 60, 20); steps(10);
    set_veg(130, 130, 20); steps(5 * 7);
    set_veg(60, 60, 20); steps(10);

    // Clamp at zero: pig near origin with growth >= 20
    set_pig(10, 10);
    set_veg(2000, 2000, 20); steps(10);
    set_veg(0, 0, 3); steps(10);
    set_veg(1900, 0, 20); steps(10);

    // Persistent overlap: growth and score saturation, start ignored
    set_pig(100, 100);
    set_veg(130, 130, 20);
    for (int i = 0; i < 1900; i++) begin
      start = ($urandom_range(0, 9) == 0);
      step();
    end
    start = 1'b0;

    // Randomized traffic with an occasional reset
    rst = 1'b1; steps(1); rst = 1'b0;
    pulse_start();
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 399) == 0);
      start = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0)
        set_pig($urandom_range(0, 300), $urandom_range(0, 300));
      if ($urandom_range(0, 199) == 0)
        set_pig($urandom_range(1900, 2047), $urandom_range(1900, 2047));
      if (new_round || $urandom_range(0, 7) == 0) begin
        vx = int'(pig_x) + int'($urandom_range(0, 150)) - 75;
        vy = int'(pig_y) + int'($urandom_range(0, 150)) - 75;
        if (vx < 0) vx = 0;
        if (vy < 0) vy = 0;
        if (vx > 2000) vx = 2000;
        if (vy > 2000) vy = 2000;
        set_veg(vx, vy, $urandom_range(0, 30));
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vegetable_eater.md
# vegetable_eater

Consumer end of the vegetable position interface. Compares the pig bounding box against the current vegetable box each cycle and debounces the overlap. On a confirmed bite it issues a one-cycle `new_round` pulse that makes the vegetable locator respawn the vegetable, grows the pig, and increments the score. It then holds off until the new vegetable position has settled.

## Interface
- `PIG_SIZE`, 40: base pig edge length in pixels.
- `GROWTH_STEP`, 4: pixels added to `pig_growth` per bite.
- `MAX_GROWTH`, 40: saturation limit of `pig_growth`.
- `HIT_CYCLES`, 2: consecutive overlap samples needed to confirm a bite (≥1).
- `COOLDOWN_CYCLES`, 4: hold-off after a bite before re-arming (≥2).
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  level or pulse; leaves IDLE and clears score and growth.
- `pigX`, `pigY`  in  11  pig top-left corner.
- `posX`, `posY`  in  11  vegetable top-left corner, from the locator.
- `posX_end`, `posY_end`  in  11  vegetable bottom-right corner, from the locator.
- `new_round`  out  1  registered one-cycle respawn pulse to the locator.
- `pig_growth`  out  11  registered current growth, fed back to the locator.
- `score`  out  8  registered bites eaten, saturating at 255.
- `armed`  out  1  registered; high while in ARMED.

## Operation
- Pig box: X from `pigX - pig_growth` to `pigX + PIG_SIZE`; Y uses the same formula.
- All box arithmetic is 12-bit unsigned.
- If the lower edge goes below zero, it clamps to 0.
- Overlap condition: `posX_end >= pig_left`, `posX <= pig_right`, `posY_end >= pig_top`, and `posY <= pig_bottom`. Compares are inclusive.
- States:
  - IDLE: waits for `start`. On `start`: score←0, pig_growth←0, hit counter←0, go to ARMED.
  - ARMED: while overlap is true, the hit counter increments each edge; any cycle without overlap clears it to 0. At the edge where the counter would reach HIT_CYCLES, go to EAT.
  - EAT: lasts exactly one cycle. `new_round`=1. pig_growth←min(pig_growth+GROWTH_STEP, MAX_GROWTH). score←min(score+1, 255). Go to COOLDOWN.
  - COOLDOWN: counts COOLDOWN_CYCLES cycles with overlap ignored. Then hit counter←0 and go to ARMED.
- `start` is ignored outside IDLE.
- There is no path back to IDLE except `rst`.
- Growth and score saturate. They never wrap.
- If overlap persists after cooldown, for example because the locator relocation failed, a new bite needs a fresh HIT_CYCLES of overlap.

## Timing
- Reset: state IDLE, `new_round`=0, `pig_growth`=0, `score`=0, `armed`=0, both counters 0.
- Reset asserted mid-EAT or mid-COOLDOWN aborts immediately. `new_round` is low on the cycle after the reset edge.
- Latency: overlap is first sampled at edge N. With uninterrupted overlap, `new_round` is high during the cycle following edge N+HIT_CYCLES-1.
- `pig_growth` and `score` change on the same edge that raises `new_round`.
- `new_round` is never high for two consecutive cycles.
- Minimum spacing between pulses is 1 + COOLDOWN_CYCLES + HIT_CYCLES cycles.
- The locator latches its new `posX`/`posY` on the edge that samples `new_round`. COOLDOWN_CYCLES ≥ 2 guarantees the comparators see the new position before re-arming.
- `armed` rises on the edge entering ARMED and falls on the edge entering EAT.
- Inputs are sampled only at `clk` edges; no combinational path runs from inputs to outputs.

## Test plan
- Reset, then `start` pulse: `armed`=1 one cycle later, `score`=0, `pig_growth`=0. Reset during COOLDOWN returns all outputs to 0 next cycle.
- Basic bite:
  - Stimulus: pig (100,100); vegetable (130,130)–(150,150) held for 2 cycles.
  - Response: one `new_round` pulse, `score`=1, `pig_growth`=4, `armed` low for 5 cycles.
- Debounce: vegetable at (130,130)–(150,150) for 1 cycle, then at (300,300)–(320,320) → no `new_round`, hit counter cleared, `score`=0.
- Edge and growth boundary:
  - Pig (100,100), growth 0, vegetable (60,60)–(80,80): no bite.
  - Same vegetable after 5 bites (growth 20): `pig_left`=80 touches `posX_end`=80 → bite.
  - Pig (10,10) with growth 20: `pig_left` clamps to 0, no underflow false hit.
- Saturation:
  - 12 forced bites → `pig_growth` stops at 40.
  - Preload `score` to 254, then 3 bites → `score`=255.
- Persistent overlap: vegetable held overlapping forever → pulses exactly every 1+4+2=7 cycles; `start` asserted meanwhile has no effect.
